// File: rtl/uart_tx_fifo_if.sv
// Producer/uart handshake bundle for uart_tx_fifo: byte write port, FIFO status,
// and the din/send/txbusy link to the uart transmitter.
interface uart_tx_fifo_if #(
  parameter int AddrWidth = 4
);
  logic [7:0]         wdata;
  logic               wr;
  logic               full;
  logic               empty;
  logic [AddrWidth:0] count;
  logic               overflow;
  logic [7:0]         txd;
  logic               send;
  logic               txbusy;

  modport master (
    output wdata, wr, txbusy,
    input  full, empty, count, overflow, txd, send
  );

  modport slave (
    input  wdata, wr, txbusy,
    output full, empty, count, overflow, txd, send
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart transmitter: producers push bytes at any rate and a
// three-state sequencer hands them to the uart one at a time via send/txbusy.
module uart_tx_fifo #(
  parameter int AddrWidth = 4
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  localparam int Depth = 1 << AddrWidth;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUSY
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           mem_q [Depth];
  logic [AddrWidth-1:0] wp_q, wp_d;
  logic [AddrWidth-1:0] rp_q, rp_d;
  logic [AddrWidth:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           txd_q, txd_d;
  logic                 send_q, send_d;

  logic full;
  logic empty;
  logic accept;
  logic pop;

  // Occupancy is its own register, so full and empty never depend on pointer equality.
  assign full   = (count_q == (AddrWidth + 1)'(Depth));
  assign empty  = (count_q == '0);
  assign accept = bus.wr && !full;
  assign pop    = (state_q == IDLE) && !empty && !bus.txbusy;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = bus.wr && full;
    if (accept) begin
      wp_d = wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
    end
    if (accept && !pop) begin
      count_d = count_q + (AddrWidth + 1)'(1);
    end else if (pop && !accept) begin
      count_d = count_q - (AddrWidth + 1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    txd_d   = txd_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          txd_d   = mem_q[rp_q];
          send_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.txbusy) begin
          send_d  = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!bus.txbusy) begin
          state_d = IDLE;
        end
      end
      default: begin
        send_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      txd_q      <= 8'h00;
      send_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      txd_q      <= txd_d;
      send_q     <= send_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define valid data.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wp_q] <= bus.wdata;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.txd      = txd_q;
  assign bus.send     = send_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed-plus-random bench for uart_tx_fifo with a simple uart model and a
// queue-based reference of which bytes must reach the line, in order.
module tb_uart_tx_fifo;

  logic clk;
  logic reset;

  uart_tx_fifo_if #(.AddrWidth(4)) bus ();

  uart_tx_fifo #(.AddrWidth(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int busyLen   = 20;
  int busyLeft  = 0;
  bit forceBusy = 1'b0;
  int sendViol  = 0;
  int ovfCount  = 0;
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Uart model: takes a byte when send is seen, then stays busy for busyLen cycles.
  initial begin
    bus.txbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (forceBusy) begin
        bus.txbusy = 1'b1;
      end else if (busyLeft > 0) begin
        if (bus.send) sendViol++;
        busyLeft--;
        if (busyLeft == 0) bus.txbusy = 1'b0;
      end else begin
        bus.txbusy = 1'b0;
        if (bus.send) begin
          rxQ.push_back(bus.txd);
          bus.txbusy = 1'b1;
          busyLeft   = busyLen;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.overflow) ovfCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit expectAccept);
    bus.wdata = b;
    bus.wr    = 1'b1;
    if (expectAccept) expQ.push_back(b);
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
  endtask

  task automatic waitDrain(input string tag, input int maxCycles);
    int quiet = 0;
    for (int i = 0; i < maxCycles && quiet < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.empty && !bus.send && !bus.txbusy && busyLeft == 0) quiet++;
      else quiet = 0;
    end
    checkOutput(tag, 32'(quiet >= 3), 32'd1);
  endtask

  task automatic compareRx(input string tag);
    checkOutput({tag, "_len"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      checkOutput(tag, rxQ[i], expQ[i]);
    end
    rxQ.delete();
    expQ.delete();
  endtask

  initial begin
    logic [7:0] base;
    logic [7:0] x;
    logic [7:0] y;
    int ovfStart;
    bit sendSeen;

    reset     = 1'b0;
    bus.wr    = 1'b0;
    bus.wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_count", bus.count, 0);
    checkOutput("rst_empty", bus.empty, 1);
    checkOutput("rst_full", bus.full, 0);
    checkOutput("rst_overflow", bus.overflow, 0);
    checkOutput("rst_send", bus.send, 0);
    checkOutput("rst_txd", bus.txd, 8'h00);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single byte");
    busyLen = 20;
    applyStimulus(8'hA5, 1'b1);
    checkOutput("single_count_n", bus.count, 1);
    checkOutput("single_send_n", bus.send, 0);
    @(posedge clk);
    #1;
    checkOutput("single_send_n1", bus.send, 1);
    checkOutput("single_txd_n1", bus.txd, 8'hA5);
    checkOutput("single_count_n1", bus.count, 0);
    @(posedge clk);
    #1;
    checkOutput("single_send_drop", bus.send, 0);
    checkOutput("single_txd_hold", bus.txd, 8'hA5);
    waitDrain("single_drain", 200);
    compareRx("single_rx");

    $display("[TB] burst ordering");
    ovfStart = ovfCount;
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b1);
    waitDrain("burst_drain", 2000);
    checkOutput("burst_no_overflow", ovfCount - ovfStart, 0);
    compareRx("burst_rx");

    $display("[TB] overflow");
    forceBusy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ovfStart = ovfCount;
    for (int i = 0; i < 16; i++) applyStimulus(8'($urandom), 1'b1);
    checkOutput("ovf_full", bus.full, 1);
    checkOutput("ovf_count16", bus.count, 16);
    applyStimulus(8'($urandom), 1'b0);
    checkOutput("ovf_pulse", bus.overflow, 1);
    checkOutput("ovf_count_kept", bus.count, 16);
    @(posedge clk);
    #1;
    checkOutput("ovf_pulse_end", bus.overflow, 0);
    checkOutput("ovf_pulse_count", ovfCount - ovfStart, 1);
    forceBusy = 1'b0;
    waitDrain("ovf_drain", 2000);
    compareRx("ovf_rx");

    $display("[TB] simultaneous push and pop");
    forceBusy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    x = 8'($urandom);
    y = 8'($urandom);
    applyStimulus(x, 1'b1);
    checkOutput("sim_count_pre", bus.count, 1);
    forceBusy = 1'b0;
    applyStimulus(y, 1'b1);
    checkOutput("sim_count", bus.count, 1);
    checkOutput("sim_send", bus.send, 1);
    checkOutput("sim_txd", bus.txd, x);
    waitDrain("sim_drain", 500);
    compareRx("sim_rx");

    $display("[TB] wrap-around");
    busyLen  = 3;
    ovfStart = ovfCount;
    base     = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'(base + 8'(i)), 1'b1);
      repeat ($urandom_range(5, 8)) @(posedge clk);
      #1;
    end
    waitDrain("wrap_drain", 500);
    checkOutput("wrap_empty", bus.empty, 1);
    checkOutput("wrap_count", bus.count, 0);
    checkOutput("wrap_no_overflow", ovfCount - ovfStart, 0);
    compareRx("wrap_rx");

    $display("[TB] reset mid-burst");
    busyLen   = 20;
    forceBusy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), 1'b1);
    forceBusy = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rmid_in_req", bus.send, 1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rmid_send", bus.send, 0);
    checkOutput("rmid_count", bus.count, 0);
    checkOutput("rmid_empty", bus.empty, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    expQ.delete();
    sendSeen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.send) sendSeen = 1'b1;
    end
    checkOutput("rmid_quiet", sendSeen, 0);
    compareRx("rmid_rx");

    checkOutput("send_while_busy", sendViol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
